// File: rtl/countdown_controller.sv
// Countdown controller for the bomb-timer register.
// Drives the register's ctrl/data inputs: loads the preset on arm, issues one
// DEC per prescaled tick, and reports armed / defused / detonated status.
//
// Register control codes (must match the timer register):
//   REG_CTRL_NONE = 0 (hold), REG_CTRL_CLR = 1, REG_CTRL_LD = 2,
//   REG_CTRL_INC  = 3,        REG_CTRL_DEC = 4
//
// All outputs are registered. A code driven on reg_ctrl in cycle N is applied
// by the register at edge N+1, and every code lasts exactly one cycle.
// The count input is read back only for the == 0 / == 1 expiry decision.
module countdown_controller #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000000,
  localparam int REG_CTRL_WIDTH = 3
) (
  input  logic                      async_reset,
  input  logic                      clk,
  input  logic                      arm,
  input  logic                      defuse,
  input  logic [WIDTH-1:0]          preset,
  input  logic [WIDTH-1:0]          count,
  output logic [REG_CTRL_WIDTH-1:0] reg_ctrl,
  output logic [WIDTH-1:0]          reg_data,
  output logic                      tick,
  output logic                      armed,
  output logic                      defused,
  output logic                      detonated
);

  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NONE = 3'd0;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_CLR  = 3'd1;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD   = 3'd2;
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC  = 3'd3; // never issued
  localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_DEC  = 3'd4;

  localparam int              PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    DEFUSED   = 2'd2,
    DETONATED = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [PW-1:0]             presc, presc_nxt;
  logic [REG_CTRL_WIDTH-1:0] ctrl_nxt;
  logic [WIDTH-1:0]          data_nxt;
  logic                      tick_nxt;

  // Next-state, prescaler and register-command decode.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    ctrl_nxt  = REG_CTRL_NONE;
    data_nxt  = reg_data;
    tick_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        // A zero preset would expire immediately, so it is not a valid start.
        presc_nxt = '0;
        if (arm && (preset != '0)) begin
          ctrl_nxt  = REG_CTRL_LD;
          data_nxt  = preset;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        // Defuse wins over a tick or expiry landing in the same cycle.
        if (defuse) begin
          state_nxt = DEFUSED;
        end else if (presc == TERM) begin
          presc_nxt = '0;
          tick_nxt  = 1'b1;
          if (count == '0) begin
            // Never DEC a zero register: it would wrap to all-ones.
            state_nxt = DETONATED;
          end else begin
            ctrl_nxt = REG_CTRL_DEC;
            if (count == WIDTH'(1)) state_nxt = DETONATED;
          end
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      DEFUSED, DETONATED: begin
        // Return to idle only; the preset is not sampled on this pulse.
        if (arm) begin
          ctrl_nxt  = REG_CTRL_CLR;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state     <= IDLE;
      presc     <= '0;
      reg_ctrl  <= REG_CTRL_NONE;
      reg_data  <= '0;
      tick      <= 1'b0;
      armed     <= 1'b0;
      defused   <= 1'b0;
      detonated <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      reg_ctrl  <= ctrl_nxt;
      reg_data  <= data_nxt;
      tick      <= tick_nxt;
      armed     <= (state_nxt == ARMED);
      defused   <= (state_nxt == DEFUSED);
      detonated <= (state_nxt == DETONATED);
    end
  end

endmodule

// File: doc/countdown_controller.md
Name: countdown_controller

Overview:
- Control FSM directly upstream of the bomb-timer register.
- Generates the register's ctrl code and load data: loads the preset on arm, issues one DEC per prescaled tick, and detects expiry or defuse.
- Reads the register's output back to decide when to stop.
- Sole driver of the timer register's ctrl/data_input; status outputs feed the display and LED logic.

Parameters:
- WIDTH, 8, width of preset/count/reg_data; must match the timer register's WIDTH.
- TICK_DIV, 50000000, clk cycles per countdown tick (1 s at 50 MHz); legal range >= 2.

Ports:
- async_reset  input  1  asynchronous, active-low reset
- clk  input  1  single clock; all logic on posedge
- arm  input  1  one-cycle pulse (already debounced/edge-detected); start, or return to idle
- defuse  input  1  one-cycle pulse; correct disarm code entered
- preset  input  WIDTH  start value, sampled on arm in IDLE
- count  input  WIDTH  current timer register value (its data_output)
- reg_ctrl  output  REG_CTRL_WIDTH  register control: REG_CTRL_CLR/LD/INC/DEC, or REG_CTRL_NONE for hold
- reg_data  output  WIDTH  register load data
- tick  output  1  one-cycle pulse at each prescaler terminal count while ARMED
- armed  output  1  high in ARMED
- defused  output  1  high in DEFUSED
- detonated  output  1  high in DETONATED

Behaviour:
- Reset values (async_reset low, immediate):
  - State IDLE, prescaler 0.
  - reg_ctrl = REG_CTRL_NONE, reg_data = 0.
  - tick, armed, defused, detonated all 0.
- Reset mid-countdown aborts to IDLE. The register has its own reset, so there is no CLR pulse.
- reg_ctrl and reg_data are registered: a code asserted in cycle N is applied by the register at edge N+1. Every code lasts exactly one cycle; REG_CTRL_NONE is driven otherwise.
- reg_data = preset captured at arm; it holds its value between loads.
- REG_CTRL_INC is never issued.
- State IDLE:
  - arm=1 and preset != 0: reg_ctrl = LD, reg_data = preset, prescaler cleared, go ARMED.
  - arm=1 and preset == 0: ignored, stay IDLE.
  - defuse ignored.
- State ARMED (armed=1):
  - Prescaler increments 0..TICK_DIV-1 and wraps to 0.
  - At wrap: tick=1 for that cycle.
    - If count > 1: reg_ctrl = DEC, stay ARMED.
    - If count == 1: reg_ctrl = DEC, go DETONATED (register reads 0 one cycle later).
    - If count == 0 (defensive): no DEC, go DETONATED.
  - The first tick occurs TICK_DIV cycles after entering ARMED.
  - defuse=1: go DEFUSED, no DEC, prescaler frozen. Defuse has priority over a same-cycle tick/expiry.
  - arm=1 in ARMED: ignored (no re-trigger).
- State DEFUSED (defused=1): register holds its value (remaining time stays on display); defuse ignored.
- State DETONATED (detonated=1): defuse ignored.
- DEFUSED or DETONATED with arm=1: reg_ctrl = CLR, go IDLE. The preset is not sampled on this pulse, so a new arm is needed to restart.
- Status outputs are registered from the next state and change on the same edge as the state.
- count is trusted only for the == 0 / == 1 comparison; no width extension or arithmetic in this block.
- Wrap/underflow: the block never issues DEC when count == 0, so the register cannot wrap to all-ones.

Test Plan (WIDTH=8, TICK_DIV=4):
- Reset, then preset=3 and arm pulse -> next cycle reg_ctrl=LD, reg_data=3, armed=1; register reads 3; DEC pulses every 4 cycles (count 2, 1); DEC at count 1 -> detonated=1, armed=0, count=0; no further DEC over 20 cycles.
- preset=0 and arm -> stays IDLE, reg_ctrl=NONE, all status 0.
- preset=5, arm, defuse after 6 cycles -> defused=1; count frozen at 4; no tick/DEC for 20 cycles; then arm -> reg_ctrl=CLR for one cycle, IDLE, count=0.
- preset=1, arm, defuse asserted in exactly the tick cycle -> defused=1, detonated=0, count stays 1, no DEC issued.
- preset=9, arm, async_reset low for 1 cycle mid-prescaler -> outputs immediately at reset values, IDLE; after release the next arm with preset=2 reloads 2 and the first tick comes 4 cycles later.
- In ARMED, extra arm pulses and defuse pulses in IDLE -> ignored; tick spacing remains exactly 4 cycles.
